// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction fetch req/gnt/rvalid protocol.
// Word-addressed RAM, bounded outstanding requests, fixed-latency in-order responses.
module instr_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned AW             = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_wdata_i
);

    localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] BYTES = 33'(MEM_WORDS) * 33'd4;

    if (LATENCY == 0 || MAX_OUTSTANDING == 0) begin : g_bad_cfg
        $error("instr_mem_responder: LATENCY and MAX_OUTSTANDING must both be >= 1");
    end

    logic [31:0]        ram [MEM_WORDS];
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_busy;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        dat_q [LATENCY];
    logic [AW-1:0]      rd_idx;
    logic               oor;

    assign rd_idx   = instr_addr_i[AW+1:2];
    assign oor      = {1'b0, instr_addr_i} >= BYTES;
    // a response retiring this cycle frees its slot for an immediate grant
    assign cnt_busy = cnt_q - CW'(instr_rvalid_o);

    assign instr_gnt_o = instr_req_i & ~ld_we_i & (cnt_busy < CW'(MAX_OUTSTANDING));

    // Loader write port; grants are blocked while it is active so reads never collide.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            ram[ld_addr_i] <= ld_wdata_i;
        end
    end

    // Response pipeline: bubbles and errored entries carry zero data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= instr_gnt_o;
            err_q[0] <= instr_gnt_o & oor;
            dat_q[0] <= (instr_gnt_o && !oor) ? ram[rd_idx] : '0;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_err_o    = err_q[LATENCY-1];
    assign instr_rdata_o  = dat_q[LATENCY-1];

    // Outstanding counter: granted requests whose response has not yet retired.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_cnt_bounds: assert property (@(posedge clk) disable iff (!rstn)
        (cnt_q <= CW'(MAX_OUTSTANDING)) && !(instr_rvalid_o && (cnt_q == '0)))
        else $error("instr_mem_responder: outstanding counter out of range");

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed literal cases plus randomized traffic
// checked every cycle against a due-time response queue model.
module tb_instr_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned LAT       = 3;
    localparam int unsigned MAXO      = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata;

    int errors = 0;
    int checks = 0;

    instr_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
        .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [MEM_WORDS];
    int          t = 0;

    always @(negedge clk) begin
        logic exp_rv;
        logic exp_g;
        rsp_t r;
        if (!rstn) begin
            q.delete();
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_gnt", 32'(gnt), 32'(req && !ld_we));
        end else begin
            exp_rv = (q.size() > 0) && (q[0].due == t);
            chk("rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv) begin
                r = q.pop_front();
                chk("err", 32'(err), 32'(r.err));
                chk("rdata", rdata, r.data);
            end else begin
                chk("idle_err", 32'(err), 32'd0);
                chk("idle_rdata", rdata, 32'd0);
            end
            exp_g = req && !ld_we && (q.size() < int'(MAXO));
            chk("gnt", 32'(gnt), 32'(exp_g));
            if (exp_g) begin
                r.due = t + int'(LAT);
                r.err = (64'(addr) >= 64'(MEM_WORDS) * 4);
                r.data = r.err ? 32'd0 : mem_m[addr / 4];
                q.push_back(r);
            end
        end
        if (ld_we) mem_m[ld_addr] = ld_wdata;
        t++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        ld_we = 1'b0;
        repeat (n) step();
    endtask

    bit gpat [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    bit rpat [8] = '{0, 0, 0, 1, 1, 0, 1, 1};

    initial begin
        logic gs;
        int k;
        int r;
        rstn = 1'b0; req = 1'b0; addr = '0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        @(negedge clk);
        chk("lit_reset_rvalid", 32'(rvalid), 32'd0);
        step();
        rstn = 1'b1;

        // preload words 0..63 and the last word
        for (int i = 0; i < 64; i++) begin
            ld_we = 1'b1; ld_addr = 10'(i);
            ld_wdata = (i == 2) ? 32'hDEADBEEF : $urandom;
            step();
        end
        ld_addr = 10'd1023; ld_wdata = 32'hA5A55A5A;
        step();
        idle(2);

        // single read of ram[2]
        req = 1'b1; addr = 32'h8;
        @(negedge clk); chk("lit_t1_gnt", 32'(gnt), 32'd1);
        step(); req = 1'b0;
        step(); step();
        @(negedge clk);
        chk("lit_t1_rvalid", 32'(rvalid), 32'd1);
        chk("lit_t1_rdata", rdata, 32'hDEADBEEF);
        chk("lit_t1_err", 32'(err), 32'd0);
        step();
        @(negedge clk); chk("lit_t1_single", 32'(rvalid), 32'd0);
        idle(4);

        // back-to-back requests throttled by the outstanding limit
        k = 0;
        for (int c = 0; c < 8; c++) begin
            req = (k < 4); addr = 32'(k * 4);
            @(negedge clk);
            chk("lit_t2_gnt", 32'(gnt), 32'(gpat[c]));
            chk("lit_t2_rvalid", 32'(rvalid), 32'(rpat[c]));
            if (gpat[c]) k++;
            step();
        end
        idle(4);

        // out-of-range access just past the top, then the last valid byte
        req = 1'b1; addr = 32'h1000;
        @(negedge clk); chk("lit_t3_gnt", 32'(gnt), 32'd1);
        step(); addr = 32'hFFF;
        @(negedge clk); chk("lit_t3b_gnt", 32'(gnt), 32'd1);
        step(); req = 1'b0;
        step();
        @(negedge clk);
        chk("lit_t3_rvalid", 32'(rvalid), 32'd1);
        chk("lit_t3_err", 32'(err), 32'd1);
        chk("lit_t3_rdata", rdata, 32'd0);
        step();
        @(negedge clk);
        chk("lit_t3b_err", 32'(err), 32'd0);
        chk("lit_t3b_rdata", rdata, 32'hA5A55A5A);
        idle(4);

        // loader write blocks a simultaneous request, which then reads the new data
        req = 1'b1; addr = 32'hC; ld_we = 1'b1; ld_addr = 10'd3; ld_wdata = 32'h12345678;
        @(negedge clk); chk("lit_t4_gnt_blocked", 32'(gnt), 32'd0);
        step(); ld_we = 1'b0;
        @(negedge clk); chk("lit_t4_gnt", 32'(gnt), 32'd1);
        step(); req = 1'b0;
        step(); step();
        @(negedge clk);
        chk("lit_t4_rvalid", 32'(rvalid), 32'd1);
        chk("lit_t4_rdata", rdata, 32'h12345678);
        idle(4);

        // reset while two responses are in flight
        req = 1'b1; addr = 32'h0;
        @(negedge clk); chk("lit_t5_gnt0", 32'(gnt), 32'd1);
        step(); addr = 32'h4;
        @(negedge clk); chk("lit_t5_gnt1", 32'(gnt), 32'd1);
        step(); req = 1'b0; rstn = 1'b0;
        @(negedge clk); chk("lit_t5_rst_rvalid", 32'(rvalid), 32'd0);
        step(); rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("lit_t5_dropped", 32'(rvalid), 32'd0);
            step();
        end
        req = 1'b1; addr = 32'h8;
        @(negedge clk); chk("lit_t5_regrant", 32'(gnt), 32'd1);
        step();
        idle(4);

        // randomized traffic; address held until granted
        gs = 1'b0;
        req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!rstn) rstn = 1'b1;
            if (!req || gs) begin
                req = ($urandom % 10) < 7;
                r = int'($urandom % 100);
                if (r < 12) addr = $urandom | 32'h1000;
                else if (r < 17) addr = 32'hFFC | 32'($urandom % 4);
                else addr = 32'($urandom_range(0, 255));
            end
            ld_we = ($urandom % 10) == 0;
            ld_addr = 10'($urandom % 64);
            ld_wdata = $urandom;
            if (($urandom % 400) == 0) rstn = 1'b0;
            @(negedge clk);
            gs = gnt;
            step();
        end
        rstn = 1'b1;
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
